// File: rtl/alu_main_control.sv
// alu_main_control: multi-cycle MIPS-style main control FSM.
// Sequences FETCH -> DECODE -> per-class execute states and back to FETCH,
// producing datapath select/strobe controls. Memory accesses wait on
// mem_ready. Optional feature: define MAIN_CTRL_JAL_EN to add the JAL
// state (opcode 0x03); without it 0x03 is reported as an illegal opcode.
module alu_main_control (
    input  logic       clk,
    input  logic       rstb,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch_eq,
    output logic       branch_ne,
    output logic       iord,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_IMMEX    = 4'd9,
        S_IMMWB    = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12,
        S_JAL      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_MUL   = 6'h1C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_t     cur_st, nxt_st;
    state_t     dec_tgt;
    logic [5:0] op_q, funct_q;

    // funct is only acted on while in DECODE; the latched copy is kept so the
    // whole instruction field stays observable, and has no further consumer.
    logic unused_funct;
    assign unused_funct = ^funct_q;

    assign state = cur_st;

    // Map the live opcode/funct to the first post-DECODE state; S_FETCH means
    // the opcode is not supported.
    function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] fn);
        state_t t;
        t = S_FETCH;
        case (op)
            OP_LW, OP_SW:     t = S_MEMADR;
            OP_RTYPE:         t = (fn == FN_JR) ? S_JR : S_EXECUTE;
            OP_BEQ, OP_BNE:   t = S_BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI,
            OP_ORI, OP_XORI, OP_MUL: t = S_IMMEX;
            OP_J:             t = S_JUMP;
`ifdef MAIN_CTRL_JAL_EN
            OP_JAL:           t = S_JAL;
`endif
            default:          t = S_FETCH;
        endcase
        return t;
    endfunction

    assign dec_tgt = decode_target(op_code, funct);

    // State register, asynchronously returned to FETCH.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) cur_st <= S_FETCH;
        else       cur_st <= nxt_st;
    end

    // Capture the instruction fields on the DECODE cycle; later states use
    // only these copies so input changes mid-instruction are ignored.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            op_q    <= 6'h00;
            funct_q <= 6'h00;
        end else if (cur_st == S_DECODE) begin
            op_q    <= op_code;
            funct_q <= funct;
        end
    end

    // Next-state logic.
    always_comb begin
        nxt_st = S_FETCH;
        case (cur_st)
            S_FETCH:    nxt_st = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   nxt_st = dec_tgt;
            S_MEMADR:   nxt_st = (op_q == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  nxt_st = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    nxt_st = S_FETCH;
            S_MEMWRITE: nxt_st = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  nxt_st = S_ALUWB;
            S_ALUWB:    nxt_st = S_FETCH;
            S_BRANCH:   nxt_st = S_FETCH;
            S_IMMEX:    nxt_st = S_IMMWB;
            S_IMMWB:    nxt_st = S_FETCH;
            S_JUMP:     nxt_st = S_FETCH;
            S_JR:       nxt_st = S_FETCH;
            default:    nxt_st = S_FETCH;
        endcase
    end

    // Output decode: Moore per state, except the FETCH strobes follow
    // mem_ready (and are held off while reset is asserted) and illegal_op
    // follows the live opcode in DECODE.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch_eq  = 1'b0;
        branch_ne  = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        illegal_op = 1'b0;
        case (cur_st)
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready & rstb;
                pc_write  = mem_ready & rstb;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = (dec_tgt == S_FETCH);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMREAD: iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_dst   = 2'b01;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch_eq = (op_q == OP_BEQ);
                branch_ne = (op_q == OP_BNE);
            end
            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            S_IMMWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            S_JR: begin
                pc_src   = 2'b11;
                pc_write = 1'b1;
            end
`ifdef MAIN_CTRL_JAL_EN
            S_JAL: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                reg_write  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_main_control.sv
// Self-checking bench for alu_main_control: directed instruction table,
// hand-written wait/reset sequences, and randomized instruction streams
// checked against a per-instruction expected state trace.
module tb_alu_main_control;

    logic       clk = 1'b0;
    logic       rstb;
    logic [5:0] op_code, funct;
    logic       mem_ready;
    logic       ir_write, pc_write, branch_eq, branch_ne, iord, mem_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src, alu_op;
    logic       alu_src_a, illegal_op;
    logic [3:0] state;

    alu_main_control dut (
        .clk(clk), .rstb(rstb), .op_code(op_code), .funct(funct), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .branch_eq(branch_eq), .branch_ne(branch_ne),
        .iord(iord), .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir, pcw, beq, bne, iord, memw, regw;
        logic [1:0] rdst, m2r;
        logic       srca;
        logic [1:0] srcb, pcsrc, aluop;
        logic       ill;
        logic [3:0] st;
    } ctl_t;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic       ill;
        logic [5:0] op, fn;
    } rec_t;

    typedef struct {
        logic [5:0]      op, fn;
        logic            ill;
        int              len;
        logic [5:0][3:0] path;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   mw_cnt = 0;
    rec_t trace[$];

`ifdef MAIN_CTRL_JAL_EN
    localparam bit JAL_ON = 1'b1;
`else
    localparam bit JAL_ON = 1'b0;
`endif

    // Expected outputs for one cycle, straight from the per-state output list.
    function automatic ctl_t exp_out(rec_t r);
        ctl_t e;
        e = '0;
        e.st = r.st;
        case (r.st)
            4'd0:  begin e.srcb = 2'b01; e.ir = r.mr; e.pcw = r.mr; end
            4'd1:  begin e.srcb = 2'b11; e.ill = r.ill; end
            4'd2:  begin e.srca = 1; e.srcb = 2'b10; end
            4'd3:  e.iord = 1;
            4'd4:  begin e.m2r = 2'b01; e.regw = 1; end
            4'd5:  begin e.iord = 1; e.memw = 1; end
            4'd6:  begin e.srca = 1; e.aluop = 2'b10; end
            4'd7:  begin e.rdst = 2'b01; e.regw = 1; end
            4'd8:  begin e.srca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01;
                         e.beq = (r.op == 6'h04); e.bne = (r.op == 6'h05); end
            4'd9:  begin e.srca = 1; e.srcb = 2'b10; e.aluop = 2'b11; end
            4'd10: e.regw = 1;
            4'd11: begin e.pcsrc = 2'b10; e.pcw = 1; end
            4'd12: begin e.pcsrc = 2'b11; e.pcw = 1; end
            4'd13: begin e.pcsrc = 2'b10; e.pcw = 1; e.rdst = 2'b10; e.m2r = 2'b10; e.regw = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic ctl_t act_out();
        return {ir_write, pc_write, branch_eq, branch_ne, iord, mem_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op, illegal_op, state};
    endfunction

    task automatic check(string name, rec_t r);
        ctl_t e, a;
        e = exp_out(r);
        a = act_out();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (state %0d exp %0d)", name, a, e, a.st, e.st);
        end
    endtask

    function automatic rec_t mk(logic [3:0] st, logic mr, logic ill, logic [5:0] op, logic [5:0] fn);
        rec_t r;
        r.st = st; r.mr = mr; r.ill = ill; r.op = op; r.fn = fn;
        return r;
    endfunction

    // Append the expected cycle trace of one instruction: fw FETCH stalls,
    // DECODE, then the execute states of its class with mw memory stalls.
    task automatic add_instr(logic [5:0] op, logic [5:0] fn, int fw, int mw);
        logic rm;
        bit   bad;
        for (int i = 0; i < fw; i++) trace.push_back(mk(4'd0, 1'b0, 1'b0, op, fn));
        trace.push_back(mk(4'd0, 1'b1, 1'b0, op, fn));
        bad = !(op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D,
                           6'h0E, 6'h1C, 6'h23, 6'h2B}) && !(op == 6'h03 && JAL_ON);
        rm = 1'($urandom);
        trace.push_back(mk(4'd1, rm, bad, op, fn));
        if (op == 6'h23 || op == 6'h2B) begin
            trace.push_back(mk(4'd2, 1'($urandom), 0, op, fn));
            for (int i = 0; i < mw; i++) trace.push_back(mk(op == 6'h23 ? 4'd3 : 4'd5, 0, 0, op, fn));
            trace.push_back(mk(op == 6'h23 ? 4'd3 : 4'd5, 1, 0, op, fn));
            if (op == 6'h23) trace.push_back(mk(4'd4, 1'($urandom), 0, op, fn));
        end else if (op == 6'h00 && fn == 6'h08) begin
            trace.push_back(mk(4'd12, 1'($urandom), 0, op, fn));
        end else if (op == 6'h00) begin
            trace.push_back(mk(4'd6, 1'($urandom), 0, op, fn));
            trace.push_back(mk(4'd7, 1'($urandom), 0, op, fn));
        end else if (op == 6'h04 || op == 6'h05) begin
            trace.push_back(mk(4'd8, 1'($urandom), 0, op, fn));
        end else if (op == 6'h02) begin
            trace.push_back(mk(4'd11, 1'($urandom), 0, op, fn));
        end else if (op == 6'h03 && JAL_ON) begin
            trace.push_back(mk(4'd13, 1'($urandom), 0, op, fn));
        end else if (!bad) begin
            trace.push_back(mk(4'd9, 1'($urandom), 0, op, fn));
            trace.push_back(mk(4'd10, 1'($urandom), 0, op, fn));
        end
    endtask

    // Drive the queued trace one cycle per record. The real opcode/funct are
    // only presented in DECODE; every other cycle carries random junk.
    task automatic apply_trace(string name);
        rec_t r;
        while (trace.size() > 0) begin
            r = trace.pop_front();
            op_code   = (r.st == 4'd1) ? r.op : 6'($urandom);
            funct     = (r.st == 4'd1) ? r.fn : 6'($urandom);
            mem_ready = r.mr;
            @(negedge clk);
            check(name, r);
            if (mem_write) mw_cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    vec_t tbl[10];
    logic [5:0] legal_ops[13] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                  6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h1C, 6'h23};

    initial begin
        // Directed table: opcode, funct, illegal, path length, state path (LSB first).
        tbl[0] = '{6'h23, 6'h00, 1'b0, 5, {4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}};
        tbl[1] = '{6'h2B, 6'h00, 1'b0, 4, {4'd0, 4'd0, 4'd5, 4'd2, 4'd1, 4'd0}};
        tbl[2] = '{6'h00, 6'h20, 1'b0, 4, {4'd0, 4'd0, 4'd7, 4'd6, 4'd1, 4'd0}};
        tbl[3] = '{6'h00, 6'h08, 1'b0, 3, {4'd0, 4'd0, 4'd0, 4'd12, 4'd1, 4'd0}};
        tbl[4] = '{6'h04, 6'h00, 1'b0, 3, {4'd0, 4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
        tbl[5] = '{6'h05, 6'h11, 1'b0, 3, {4'd0, 4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
        tbl[6] = '{6'h08, 6'h00, 1'b0, 4, {4'd0, 4'd0, 4'd10, 4'd9, 4'd1, 4'd0}};
        tbl[7] = '{6'h02, 6'h00, 1'b0, 3, {4'd0, 4'd0, 4'd0, 4'd11, 4'd1, 4'd0}};
        tbl[8] = '{6'h3F, 6'h00, 1'b1, 2, {4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};
        if (JAL_ON) tbl[9] = '{6'h03, 6'h00, 1'b0, 3, {4'd0, 4'd0, 4'd0, 4'd13, 4'd1, 4'd0}};
        else        tbl[9] = '{6'h03, 6'h00, 1'b1, 2, {4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};

        // Reset: FETCH values with the mem_ready-gated strobes held off.
        rstb = 1'b0; op_code = 6'h23; funct = 6'h00; mem_ready = 1'b1;
        #2;
        check("reset", mk(4'd0, 1'b0, 1'b0, 6'h00, 6'h00));
        @(posedge clk); #1;
        rstb = 1'b1;

        // Directed table, mem_ready held high.
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].len; k++)
                trace.push_back(mk(tbl[i].path[k], 1'b1, (k == 1) ? tbl[i].ill : 1'b0,
                                   tbl[i].op, tbl[i].fn));
            apply_trace($sformatf("tbl%0d_op%02h", i, tbl[i].op));
        end

        // Store with three memory stall cycles: mem_write held four cycles.
        mw_cnt = 0;
        add_instr(6'h2B, 6'h00, 0, 3);
        apply_trace("sw_wait");
        checks++;
        if (mw_cnt != 4) begin
            errors++;
            $display("FAIL sw_wait_len: mem_write cycles %0d expected 4", mw_cnt);
        end

        // Reset while a store is stalled in MEMWRITE.
        trace.push_back(mk(4'd0, 1'b1, 1'b0, 6'h2B, 6'h00));
        trace.push_back(mk(4'd1, 1'b1, 1'b0, 6'h2B, 6'h00));
        trace.push_back(mk(4'd2, 1'b1, 1'b0, 6'h2B, 6'h00));
        apply_trace("rst_mid_pre");
        mem_ready = 1'b0;
        #2;
        check("rst_mid_wait", mk(4'd5, 1'b0, 1'b0, 6'h2B, 6'h00));
        rstb = 1'b0;
        #1;
        check("rst_mid_drop", mk(4'd0, 1'b0, 1'b0, 6'h00, 6'h00));
        mem_ready = 1'b1;
        #1;
        check("rst_mid_gate", mk(4'd0, 1'b0, 1'b0, 6'h00, 6'h00));
        @(negedge clk);
        mem_ready = 1'b0;
        rstb = 1'b1;
        @(posedge clk); #1;
        add_instr(6'h08, 6'h00, 2, 0);
        apply_trace("post_rst");

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 12)];
            if (op == 6'h00 && $urandom_range(0, 1) == 0) op = 6'h2B;
            fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            add_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
            apply_trace($sformatf("rnd%0d_op%02h", n, op));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
